// File: rtl/fp_sequencer_if.sv
// Handshake bundle between the forward-propagation sequencer and the datapath
// (weight memory, MAC, activation unit, result register files).
interface fp_sequencer_if #(
  parameter int unsigned WADDR_W = 14,
  parameter int unsigned IDX_W   = 10
);
  logic               do_fp;
  logic               w_rd;
  logic [WADDR_W-1:0] w_addr;
  logic               src_sel;
  logic [IDX_W-1:0]   in_idx;
  logic               acc_clr;
  logic               acc_en;
  logic               act_start;
  logic               act_done;
  logic               res_wr;
  logic               res_layer;
  logic [IDX_W-1:0]   res_idx;
  logic               busy;
  logic               fp_done;

  modport master (
    input  do_fp, act_done,
    output w_rd, w_addr, src_sel, in_idx, acc_clr, acc_en, act_start,
           res_wr, res_layer, res_idx, busy, fp_done
  );

  modport slave (
    output do_fp, act_done,
    input  w_rd, w_addr, src_sel, in_idx, acc_clr, acc_en, act_start,
           res_wr, res_layer, res_idx, busy, fp_done
  );
endinterface

// File: rtl/fp_sequencer.sv
// Forward-propagation sequencer: walks hidden then output neurons, driving weight reads,
// MAC accumulate, activation hand-off and result write-back for each neuron.
module fp_sequencer #(
  parameter int unsigned N_IN    = 784,
  parameter int unsigned N_HID   = 15,
  parameter int unsigned N_OUT   = 10,
  parameter int unsigned WADDR_W = $clog2(N_IN * N_HID + N_HID * N_OUT),
  parameter int unsigned IDX_W   = $clog2(N_IN)
) (
  input  logic           clk,
  input  logic           rst,
  fp_sequencer_if.master bus_io
);

  localparam logic [IDX_W-1:0] LastIn  = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] LastHid = IDX_W'(N_HID - 1);
  localparam logic [IDX_W-1:0] LastOut = IDX_W'(N_OUT - 1);

  typedef enum logic [2:0] {
    StIdle, StClr, StMac, StDrain, StAct, StAwait, StWrite, StDone
  } state_e;

  state_e             state_q, state_d;
  logic               layer_q, layer_d;
  logic [IDX_W-1:0]   neuron_q, neuron_d;
  logic [IDX_W-1:0]   op_q, op_d;
  logic [WADDR_W-1:0] waddr_q, waddr_d;
  logic               acc_en_q;

  logic             w_rd, acc_clr, act_start, res_wr, fp_done;
  logic [IDX_W-1:0] last_op, last_neuron;

  assign last_op     = layer_q ? LastHid : LastIn;
  assign last_neuron = layer_q ? LastOut : LastHid;

  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    neuron_d  = neuron_q;
    op_d      = op_q;
    waddr_d   = waddr_q;
    w_rd      = 1'b0;
    acc_clr   = 1'b0;
    act_start = 1'b0;
    res_wr    = 1'b0;
    fp_done   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.do_fp) begin
          state_d  = StClr;
          layer_d  = 1'b0;
          neuron_d = '0;
          waddr_d  = '0;
        end
      end
      StClr: begin
        acc_clr = 1'b1;
        op_d    = '0;
        state_d = StMac;
      end
      StMac: begin
        w_rd    = 1'b1;
        // Weights are laid out neuron-major for both layers, so the address never rewinds.
        waddr_d = waddr_q + WADDR_W'(1);
        if (op_q == last_op) begin
          state_d = StDrain;
        end else begin
          op_d = op_q + IDX_W'(1);
        end
      end
      StDrain: state_d = StAct;
      StAct: begin
        act_start = 1'b1;
        state_d   = StAwait;
      end
      StAwait: begin
        if (bus_io.act_done) state_d = StWrite;
      end
      StWrite: begin
        res_wr = 1'b1;
        if (neuron_q != last_neuron) begin
          neuron_d = neuron_q + IDX_W'(1);
          state_d  = StClr;
        end else if (!layer_q) begin
          layer_d  = 1'b1;
          neuron_d = '0;
          state_d  = StClr;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        fp_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      layer_q  <= 1'b0;
      neuron_q <= '0;
      op_q     <= '0;
      waddr_q  <= '0;
      acc_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
      op_q     <= op_d;
      waddr_q  <= waddr_d;
      // Memory data arrives one cycle after the read strobe.
      acc_en_q <= w_rd;
    end
  end

  assign bus_io.w_rd      = w_rd;
  assign bus_io.w_addr    = waddr_q;
  assign bus_io.src_sel   = layer_q;
  assign bus_io.in_idx    = op_q;
  assign bus_io.acc_clr   = acc_clr;
  assign bus_io.acc_en    = acc_en_q;
  assign bus_io.act_start = act_start;
  assign bus_io.res_wr    = res_wr;
  assign bus_io.res_layer = layer_q;
  assign bus_io.res_idx   = neuron_q;
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.fp_done   = fp_done;

endmodule

// File: tb/tb_fp_sequencer.sv
// Directed bench for fp_sequencer in a 4-2-2 configuration: cycle-accurate vector table
// for a full pass, plus stall, restart/ignore and mid-pass reset sequences.
module tb_fp_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_sequencer_if #(.WADDR_W(4), .IDX_W(2)) bus ();

  fp_sequencer #(
    .N_IN(4), .N_HID(2), .N_OUT(2), .WADDR_W(4), .IDX_W(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct packed {
    logic       w_rd;
    logic [3:0] w_addr;
    logic       src_sel;
    logic [1:0] in_idx;
    logic       acc_clr;
    logic       acc_en;
    logic       act_start;
    logic       res_wr;
    logic       res_layer;
    logic [1:0] res_idx;
    logic       busy;
    logic       fp_done;
  } out_t;

  typedef struct {
    bit   do_fp;
    out_t exp;
  } vec_t;

  vec_t vec [0:36];
  out_t snap [0:99];
  bit   dofp [0:99];
  int   errors = 0;
  int   checks = 0;

  function automatic out_t sample();
    out_t o;
    o.w_rd = bus.w_rd;           o.w_addr = bus.w_addr;       o.src_sel = bus.src_sel;
    o.in_idx = bus.in_idx;       o.acc_clr = bus.acc_clr;     o.acc_en = bus.acc_en;
    o.act_start = bus.act_start; o.res_wr = bus.res_wr;       o.res_layer = bus.res_layer;
    o.res_idx = bus.res_idx;     o.busy = bus.busy;           o.fp_done = bus.fp_done;
    return o;
  endfunction

  // Address/index fields only carry meaning alongside their strobe.
  function automatic out_t masked(input out_t o);
    out_t m = o;
    if (!m.w_rd) begin
      m.w_addr = '0; m.src_sel = 1'b0; m.in_idx = '0;
    end
    if (!m.res_wr) begin
      m.res_layer = 1'b0; m.res_idx = '0;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic mac(input int c, input int a, input int i, input bit s, input bit en);
    vec[c].exp.w_rd = 1'b1; vec[c].exp.w_addr = 4'(a); vec[c].exp.in_idx = 2'(i);
    vec[c].exp.src_sel = s; vec[c].exp.acc_en = en;
  endtask

  task automatic wr(input int c, input bit l, input int n);
    vec[c].exp.res_wr = 1'b1; vec[c].exp.res_layer = l; vec[c].exp.res_idx = 2'(n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.do_fp = 1'b0; bus.act_done = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply_table(input string tag, input int last);
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      bus.do_fp = vec[c].do_fp;
      #1;
      snap[c] = sample();
      chk($sformatf("%s c%0d", tag, c), 32'(masked(snap[c])), 32'(vec[c].exp));
    end
    bus.do_fp = 1'b0;
  endtask

  task automatic run(input int n, input bit stall);
    int last_st = -1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bus.do_fp = dofp[c];
      if (stall) bus.act_done = (c == 3) || (c == 7) || (last_st >= 0 && c == last_st + 10);
      else       bus.act_done = 1'b1;
      #1;
      snap[c] = sample();
      if (snap[c].act_start) last_st = c;
    end
    bus.do_fp = 1'b0;
    bus.act_done = 1'b1;
  endtask

  initial begin
    int cnt [0:15];
    int bad;
    int done_c;
    int ndone;
    int nrd;
    int wr_c [$];
    int wr_exp [4] = '{18, 36, 52, 68};

    // Hand-derived 4-2-2 pass: K+5 cycles per neuron with act_done held high.
    for (int c = 0; c <= 36; c++) begin
      vec[c].do_fp = (c == 0);
      vec[c].exp   = '0;
      vec[c].exp.busy = (c >= 1 && c <= 33);
    end
    vec[33].exp.fp_done = 1'b1;
    vec[1].exp.acc_clr = 1'b1;
    mac(2, 0, 0, 0, 0); mac(3, 1, 1, 0, 1); mac(4, 2, 2, 0, 1); mac(5, 3, 3, 0, 1);
    vec[6].exp.acc_en = 1'b1; vec[7].exp.act_start = 1'b1; wr(9, 0, 0);
    vec[10].exp.acc_clr = 1'b1;
    mac(11, 4, 0, 0, 0); mac(12, 5, 1, 0, 1); mac(13, 6, 2, 0, 1); mac(14, 7, 3, 0, 1);
    vec[15].exp.acc_en = 1'b1; vec[16].exp.act_start = 1'b1; wr(18, 0, 1);
    vec[19].exp.acc_clr = 1'b1;
    mac(20, 8, 0, 1, 0); mac(21, 9, 1, 1, 1);
    vec[22].exp.acc_en = 1'b1; vec[23].exp.act_start = 1'b1; wr(25, 1, 0);
    vec[26].exp.acc_clr = 1'b1;
    mac(27, 10, 0, 1, 0); mac(28, 11, 1, 1, 1);
    vec[29].exp.acc_en = 1'b1; vec[30].exp.act_start = 1'b1; wr(32, 1, 1);

    // Reset and idle.
    bus.do_fp = 1'b0; bus.act_done = 1'b1;
    #12;
    chk("reset outputs", 32'(sample()), 32'd0);
    @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (sample() != '0) bad++;
    end
    chk("idle quiet cycles", 32'(bad), 32'd0);

    // Full pass against the vector table.
    do_reset();
    apply_table("pass", 36);
    for (int a = 0; a < 16; a++) cnt[a] = 0;
    for (int c = 0; c <= 36; c++) if (snap[c].w_rd) cnt[snap[c].w_addr]++;
    for (int a = 0; a < 12; a++) chk($sformatf("waddr cover %0d", a), 32'(cnt[a]), 32'd1);

    // Activation stall with stray act_done pulses in MAC and ACT.
    do_reset();
    for (int c = 0; c < 100; c++) dofp[c] = (c == 0);
    run(72, 1'b1);
    done_c = -1; ndone = 0; nrd = 0; bad = 0;
    for (int c = 0; c < 72; c++) begin
      if (snap[c].fp_done) begin done_c = c; ndone++; end
      if (snap[c].w_rd) nrd++;
      if (snap[c].res_wr) wr_c.push_back(c);
      if (snap[c].act_start) begin
        for (int k = c + 1; k <= c + 9 && k < 72; k++) begin
          if (snap[k].w_rd || snap[k].acc_clr || snap[k].acc_en || snap[k].act_start ||
              snap[k].res_wr || !snap[k].busy) bad++;
        end
      end
    end
    chk("stall fp_done cycle", 32'(done_c), 32'd69);
    chk("stall fp_done count", 32'(ndone), 32'd1);
    chk("stall w_rd count", 32'(nrd), 32'd12);
    chk("stall quiet cycles", 32'(bad), 32'd0);
    chk("stall res_wr count", 32'(wr_c.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall res_wr %0d cycle", i),
          32'((i < wr_c.size()) ? wr_c[i] : -1), 32'(wr_exp[i]));
    end

    // do_fp toggled mid-pass is ignored; held through DONE it restarts a pass.
    do_reset();
    for (int c = 0; c < 100; c++) dofp[c] = 1'b0;
    dofp[0] = 1; dofp[5] = 1; dofp[6] = 1; dofp[12] = 1; dofp[20] = 1;
    for (int c = 32; c <= 35; c++) dofp[c] = 1;
    run(38, 1'b0);
    bad = 0;
    for (int c = 0; c <= 34; c++) if (masked(snap[c]) != vec[c].exp) bad++;
    chk("restart ignore mismatches", 32'(bad), 32'd0);
    chk("restart clr c35", 32'(masked(snap[35])), 32'(vec[1].exp));
    chk("restart mac c36", 32'(masked(snap[36])), 32'(vec[2].exp));

    // Asynchronous reset during MAC of neuron 1, then a clean pass.
    do_reset();
    for (int c = 0; c < 100; c++) dofp[c] = (c == 0);
    run(13, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async reset outputs", 32'(sample()), 32'd0);
    @(negedge clk); rst = 1'b0;
    apply_table("after reset", 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_sequencer.md
# fp_sequencer

Forward-propagation sequencer for the two-layer network datapath. On a `do_fp` request it walks every hidden neuron, then every output neuron. For each neuron it clears the accumulator, streams weight-memory reads with matching input-operand indices into the MAC, hands the sum to the activation unit, and writes the result back. It returns `fp_done` to the top-level control FSM.

## Interface
Parameters:
- `N_IN`, 784, input pixels (layer-0 fan-in)
- `N_HID`, 15, hidden neurons (layer-1 fan-in)
- `N_OUT`, 10, output neurons
- `WADDR_W`, $clog2(N_IN*N_HID + N_HID*N_OUT), weight address width
- `IDX_W`, $clog2(N_IN), operand/result index width

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous active-high reset
- `do_fp`  in  1  start request; sampled only in IDLE
- `w_rd`  out  1  weight-memory read strobe; data valid next cycle
- `w_addr`  out  WADDR_W  weight address
- `src_sel`  out  1  operand source: 0 = image pixel, 1 = hidden activation
- `in_idx`  out  IDX_W  operand index, aligned with `w_rd`
- `acc_clr`  out  1  clear MAC accumulator
- `acc_en`  out  1  accumulate current weight×operand (`w_rd` delayed 1 cycle)
- `act_start`  out  1  one-cycle pulse: accumulator valid, begin activation
- `act_done`  in  1  activation result valid
- `res_wr`  out  1  write activation result
- `res_layer`  out  1  0 = hidden register file, 1 = output register file
- `res_idx`  out  IDX_W  neuron index for write
- `busy`  out  1  high in every state except IDLE
- `fp_done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CLR, MAC, DRAIN, ACT, AWAIT, WRITE, DONE.
- IDLE: `do_fp=1` → CLR. Layer = 0, neuron = 0, `w_addr` counter = 0.
- CLR (1 cycle): `acc_clr=1`. Operand counter = 0.
- MAC (K cycles; K = N_IN for layer 0, N_HID for layer 1):
  - `w_rd=1`; `in_idx` = operand counter; `src_sel` = layer.
  - `w_addr` increments by 1 every MAC cycle and never resets between neurons or layers.
  - Weight layout: layer 0 at j*N_IN+i; layer 1 at N_IN*N_HID + j*N_HID + i.
  - Exits to DRAIN after operand K-1.
- DRAIN (1 cycle): no read; `acc_en` still high for the last operand.
- ACT (1 cycle): `act_start=1`.
- AWAIT: hold until `act_done=1`, then WRITE. `act_done` is ignored in every other state, including ACT.
- WRITE (1 cycle): `res_wr=1`, `res_layer` = layer, `res_idx` = neuron. Next transition:
  - another neuron remains in the current layer → CLR, neuron+1;
  - last hidden neuron → CLR, layer=1, neuron=0;
  - last output neuron → DONE.
- DONE (1 cycle): `fp_done=1` → IDLE. If `do_fp` is still high in the following IDLE cycle, a new pass starts.
- `do_fp` is ignored while busy. The sequencer performs no bias add; any bias handling belongs to the activation unit.
- `acc_en` is a registered copy of `w_rd`. It therefore remains correct across the MAC→DRAIN boundary.

## Timing
- Reset (async, any state): state = IDLE, counters = 0. All outputs are 0, including `w_addr`, `in_idx`, `res_idx`, `res_layer`, `src_sel`, and the `acc_en` pipeline register. No partial pass resumes after reset.
- Cycle 0 is the cycle in which IDLE samples `do_fp=1`.
- Each neuron takes K+4+L cycles, where L ≥ 1 is the number of AWAIT cycles. L = 1 when `act_done` is high in the first AWAIT cycle.
- Total busy cycles = N_HID*(N_IN+4+L) + N_OUT*(N_HID+4+L). DONE occupies the next cycle.
- Defaults with L=1: 12035 busy cycles; `fp_done` in cycle 12036.
- Weight read latency is fixed at 1 cycle. Memory data must be valid in the cycle where `acc_en=1`.
- `act_done` held high continuously: each AWAIT lasts exactly 1 cycle.

## Test plan
- Reset/idle. Check all outputs 0 after `rst`. Hold `do_fp=0` for 50 cycles → `busy` stays 0 and no strobes fire.
- Small full pass. Use N_IN=4, N_HID=2, N_OUT=2, with `act_done` tied high. Pulse `do_fp` in cycle 0. Required response:
  - `acc_clr` in cycle 1;
  - `w_rd` in cycles 2–5 with `w_addr` 0–3;
  - `acc_en` in cycles 3–6;
  - `act_start` in cycle 7;
  - `res_wr` in cycle 9 with layer 0, idx 0;
  - final `res_wr` in cycle 32 with layer 1, idx 1;
  - `fp_done` only in cycle 33;
  - `w_addr` covers 0–11 exactly once each.
- Layer switch. In the same configuration, `src_sel=1` and `in_idx` 0–1 during layer-1 MAC. Addresses 8–11 appear in order.
- Activation stall. Hold `act_done=0` for 10 cycles after each `act_start` → no strobes during the stall, and each neuron stretches by 9 cycles. `act_done` pulses outside AWAIT are ignored.
- Restart and ignore. Toggle `do_fp` mid-pass → no effect. Hold `do_fp` high through DONE → second pass starts with `w_addr=0` in the cycle after the IDLE cycle.
- Reset mid-operation. Assert `rst` during MAC of neuron 1 → outputs go to 0 immediately (async). Next `do_fp` → full pass from `w_addr=0`, neuron 0.
